// File: rtl/line_memory_responder.sv
// Whole-line backing memory for the D-cache refill/write-back port.
// Each accepted request completes after a fixed LATENCY with a one-cycle ready pulse.
module line_memory_responder #(
  parameter int WORD_SIZE = 32,
  parameter int LINE_SIZE = 128,
  parameter int ADDR_W    = WORD_SIZE - 2,
  parameter int LINES     = 4096,
  parameter int LATENCY   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 read,
  input  logic                 write,
  input  logic [LINE_SIZE-1:0] line_in,
  output logic [LINE_SIZE-1:0] line_out,
  output logic                 ready,
  output logic                 busy,
  output logic                 err
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state, stateNext;
  logic [CNT_W-1:0]     cnt, cntNext;
  logic [IDX_W-1:0]     idxReg;
  logic                 opWrite;
  logic [LINE_SIZE-1:0] dataReg;

  logic                 accept;
  logic                 doAccess;
  logic                 accWrite;
  logic [IDX_W-1:0]     accIdx;
  logic [LINE_SIZE-1:0] accData;

  logic [LINE_SIZE-1:0] mem [LINES];

  // Word-select bits and index bits beyond LINES alias onto the same line.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{addr[1:0], addr[ADDR_W-1:2+IDX_W]};

  assign accept = (state == IDLE) && (read || write);
  assign ready  = (state == RESP);
  assign busy   = (state != IDLE);

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    doAccess  = 1'b0;
    accIdx    = idxReg;
    accWrite  = opWrite;
    accData   = dataReg;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            // Single-cycle latency: the access uses the live request directly.
            stateNext = RESP;
            doAccess  = 1'b1;
            accIdx    = addr[2 +: IDX_W];
            accWrite  = write;
            accData   = line_in;
            cntNext   = '0;
          end else begin
            stateNext = BUSY;
            cntNext   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          stateNext = RESP;
          doAccess  = 1'b1;
          cntNext   = '0;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      err      <= 1'b0;
      line_out <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept && read && write)
        err <= 1'b1;
      if (doAccess && !accWrite)
        line_out <= mem[accIdx];
    end
  end

  // Request capture: on read&write, write wins because opWrite follows write.
  always_ff @(posedge clk) begin
    if (accept) begin
      idxReg  <= addr[2 +: IDX_W];
      opWrite <= write;
      dataReg <= line_in;
    end
  end

  // A reset arriving before the access edge leaves the array untouched.
  always_ff @(posedge clk) begin
    if (doAccess && accWrite && !rst)
      mem[accIdx] <= accData;
  end

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: main instance at LATENCY=5,
// second instance at LATENCY=1; read data checked through an expectation queue.
module tb_line_memory_responder;

  localparam logic [127:0] P1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] P2 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] P3 = 128'h0F0F0F0F_12121212_34343434_56565656;
  localparam logic [127:0] P4 = 128'hFEEDFACE_BADC0FFE_0BADBEEF_13579BDF;
  localparam logic [127:0] P5 = {32{4'h5}};
  localparam logic [127:0] PA = {32{4'hA}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [29:0]  addr = '0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [127:0] line_in = '0;
  logic [127:0] line_out;
  logic         ready, busy, err;

  logic [29:0]  addr1 = '0;
  logic         read1 = 1'b0;
  logic         write1 = 1'b0;
  logic [127:0] line_in1 = '0;
  logic [127:0] line_out1;
  logic         ready1, busy1, err1;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic         isRead;
    logic [127:0] data;
  } exp_t;
  exp_t expq[$];

  always #5 clk = ~clk;

  line_memory_responder #(.LATENCY(5)) dut (
    .clk(clk), .rst(rst), .addr(addr), .read(read), .write(write),
    .line_in(line_in), .line_out(line_out), .ready(ready), .busy(busy), .err(err)
  );

  line_memory_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .addr(addr1), .read(read1), .write(write1),
    .line_in(line_in1), .line_out(line_out1), .ready(ready1), .busy(busy1), .err(err1)
  );

  task automatic chkB(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chkL(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chkI(input string tag, input int obs, input int expv);
    total++;
    assert (obs == expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every ready pulse of the main instance must match a queued expectation.
  always @(negedge clk) begin
    if (!rst && ready === 1'b1) begin
      total++;
      assert (expq.size() > 0) else begin
        bad++;
        $error("FAIL spurious_ready observed=pulse expected=none");
      end
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        if (e.isRead) chkL("read_data", line_out, e.data);
      end
    end
  end

  // One full transaction on the main instance; request dropped right after acceptance.
  task automatic txn(input logic rd, input logic wr, input logic [29:0] a,
                     input logic [127:0] d, input logic [127:0] expRead, input string tag);
    int n;
    read = rd; write = wr; addr = a; line_in = d;
    if (rd && !wr) expq.push_back(exp_t'{1'b1, expRead});
    else           expq.push_back(exp_t'{1'b0, 128'h0});
    tick();
    read = 1'b0; write = 1'b0; addr = ~a; line_in = ~d;
    chkB({tag, "_busy"}, busy, 1'b1);
    chkB({tag, "_noearly"}, ready, 1'b0);
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chkI({tag, "_latency"}, n, 4);
    tick();
    chkB({tag, "_onepulse"}, ready, 1'b0);
    chkB({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int pulses;
    int pulseAt[3];

    tick(); tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chkB("idle_ready", ready, 1'b0);
      chkB("idle_busy", busy, 1'b0);
      chkB("idle_err", err, 1'b0);
      chkL("idle_line_out", line_out, 128'h0);
    end

    // Write then read the same line back to back.
    txn(1'b0, 1'b1, 30'h40, P1, '0, "wr40");
    txn(1'b1, 1'b0, 30'h43, '0, P1, "rd43");
    tick(); tick(); tick();
    chkL("line_out_hold", line_out, P1);

    txn(1'b0, 1'b1, 30'h44, P2, '0, "wr44");
    txn(1'b1, 1'b0, 30'h44, '0, P2, "rd44");

    // Read held high across three transactions; addr wiggles while busy.
    read = 1'b1; addr = 30'h40;
    for (int i = 0; i < 3; i++) expq.push_back(exp_t'{1'b1, P1});
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i % 6 == 1) addr = 30'h44;
      if (i % 6 == 3) addr = 30'h40;
      if (i == 16) read = 1'b0;
      if (ready === 1'b1) begin
        if (pulses < 3) pulseAt[pulses] = i;
        pulses++;
      end
    end
    chkI("held_pulse_count", pulses, 3);
    chkI("held_pulse0", pulseAt[0], 4);
    chkI("held_pulse1", pulseAt[1], 10);
    chkI("held_pulse2", pulseAt[2], 16);
    tick();
    chkB("held_idle", busy, 1'b0);

    // Simultaneous read and write: write wins, error is sticky.
    txn(1'b1, 1'b1, 30'h80, P5, '0, "rw80");
    chkB("err_set", err, 1'b1);
    txn(1'b1, 1'b0, 30'h80, '0, P5, "rd80");
    chkB("err_sticky", err, 1'b1);

    // Reset in the middle of a write leaves the old line intact.
    txn(1'b0, 1'b1, 30'h100, P3, '0, "wr100");
    write = 1'b1; addr = 30'h100; line_in = PA;
    tick();
    write = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chkB("rst_busy_async", busy, 1'b0);
    chkB("rst_ready", ready, 1'b0);
    chkB("rst_err", err, 1'b0);
    chkL("rst_line_out", line_out, 128'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chkB("rst_no_ready", ready, 1'b0);
    end
    rst = 1'b0;
    tick();
    txn(1'b1, 1'b0, 30'h100, '0, P3, "rd100");

    // LATENCY=1 instance: accept at k, ready seen at k+1, next accept at k+2.
    write1 = 1'b1; addr1 = 30'h40; line_in1 = P4;
    tick();
    chkB("l1_wr_ready", ready1, 1'b1);
    chkB("l1_wr_busy", busy1, 1'b1);
    write1 = 1'b0; read1 = 1'b1; line_in1 = '0;
    tick();
    chkB("l1_guard_ready", ready1, 1'b0);
    chkB("l1_guard_busy", busy1, 1'b0);
    tick();
    chkB("l1_rd_ready", ready1, 1'b1);
    chkL("l1_rd_data", line_out1, P4);
    read1 = 1'b0;
    tick();
    chkB("l1_done", ready1, 1'b0);
    chkL("l1_hold", line_out1, P4);

    tick(); tick();
    chkI("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
